// File: rtl/i2c_master_arbiter_if.sv
// Requester and i2c_master side signals of i2c_master_arbiter.
// The master modport is the arbiter's view; slave is the environment's.
interface i2c_master_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_read;
    logic [7*NUM_REQ-1:0]          req_chip_addr;
    logic [8*NUM_REQ-1:0]          req_reg_addr;
    logic [DATA_WIDTH*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ack;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [3:0]                    rsp_status;
    logic [6:0]                    m_chip_addr;
    logic [7:0]                    m_reg_addr;
    logic [DATA_WIDTH-1:0]         m_data_in;
    logic                          m_write_en;
    logic                          m_read_en;
    logic                          m_busy;
    logic                          m_done;
    logic [3:0]                    m_status;
    logic [DATA_WIDTH-1:0]         m_data_out;
    logic                          busy;

    modport master (
        input  req_valid, req_read, req_chip_addr,
        input  req_reg_addr, req_data,
        input  m_busy, m_done, m_status, m_data_out,
        output req_ack, rsp_valid, rsp_data, rsp_status,
        output m_chip_addr, m_reg_addr, m_data_in,
        output m_write_en, m_read_en, busy
    );

    modport slave (
        output req_valid, req_read, req_chip_addr,
        output req_reg_addr, req_data,
        output m_busy, m_done, m_status, m_data_out,
        input  req_ack, rsp_valid, rsp_data, rsp_status,
        input  m_chip_addr, m_reg_addr, m_data_in,
        input  m_write_en, m_read_en, busy
    );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin front end sharing one i2c_master among NUM_REQ
// requesters, one transfer at a time, with a start timeout.
module i2c_master_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int START_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    i2c_master_arbiter_if.master bus
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = IW + 1;
    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP
    } state_t;

    state_t                state_q;
    logic [IW-1:0]         rr_ptr_q;
    logic [IW-1:0]         grant_q;
    logic [TW-1:0]         tmo_q;
    logic                  read_q;
    logic [NUM_REQ-1:0]    ack_q;
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [6:0]            chip_q;
    logic [7:0]            reg_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [3:0]            status_q;
    logic                  wen_q;
    logic                  ren_q;
    logic                  busy_q;

    logic                  found_d;
    logic [IW-1:0]         grant_d;
    logic [SW-1:0]         idx_d;
    logic                  read_d;
    logic [6:0]            chip_d;
    logic [7:0]            reg_d;
    logic [DATA_WIDTH-1:0] wdata_d;

    // Scan downward so the last hit is the nearest one at/after rr_ptr.
    always_comb begin
        found_d = 1'b0;
        grant_d = '0;
        idx_d   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx_d = {1'b0, rr_ptr_q} + SW'(k);
            if (idx_d >= SW'(NUM_REQ))
                idx_d = idx_d - SW'(NUM_REQ);
            if (bus.req_valid[idx_d[IW-1:0]]) begin
                found_d = 1'b1;
                grant_d = idx_d[IW-1:0];
            end
        end
    end

    always_comb begin
        read_d  = 1'b0;
        chip_d  = '0;
        reg_d   = '0;
        wdata_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_d == IW'(i)) begin
                read_d  = bus.req_read[i];
                chip_d  = bus.req_chip_addr[7*i +: 7];
                reg_d   = bus.req_reg_addr[8*i +: 8];
                wdata_d = bus.req_data[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            tmo_q       <= '0;
            read_q      <= 1'b0;
            ack_q       <= '0;
            rsp_valid_q <= '0;
            chip_q      <= '0;
            reg_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            status_q    <= '0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ack_q       <= '0;
            rsp_valid_q <= '0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (found_d) begin
                        grant_q <= grant_d;
                        read_q  <= read_d;
                        chip_q  <= chip_d;
                        reg_q   <= reg_d;
                        wdata_q <= wdata_d;
                        ack_q   <= NUM_REQ'(1) << grant_d;
                        busy_q  <= 1'b1;
                        state_q <= ISSUE;
                    end
                end
                // Command pulse is registered: it shows in the cycle after ack.
                ISSUE: begin
                    wen_q   <= ~read_q;
                    ren_q   <= read_q;
                    tmo_q   <= '0;
                    state_q <= WAIT_START;
                end
                WAIT_START: begin
                    if (bus.m_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (tmo_q == TW'(START_TIMEOUT - 1)) begin
                        rdata_q     <= '0;
                        status_q    <= 4'hF;
                        rsp_valid_q <= NUM_REQ'(1) << grant_q;
                        state_q     <= RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (bus.m_done || !bus.m_busy) begin
                        rdata_q     <= bus.m_data_out;
                        status_q    <= bus.m_status;
                        rsp_valid_q <= NUM_REQ'(1) << grant_q;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr_q <= (grant_q == IW'(NUM_REQ - 1)) ?
                                '0 : grant_q + 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ack     = ack_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rdata_q;
    assign bus.rsp_status  = status_q;
    assign bus.m_chip_addr = chip_q;
    assign bus.m_reg_addr  = reg_q;
    assign bus.m_data_in   = wdata_q;
    assign bus.m_write_en  = wen_q;
    assign bus.m_read_en   = ren_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Bench for i2c_master_arbiter: queued requesters, a behavioural
// i2c_master with one register slave, and a scoreboard monitor.
module tb_i2c_master_arbiter;
    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int TMO = 20;
    localparam logic [6:0] SLV  = 7'h0F;
    localparam logic [3:0] NACK = 4'h2;

    typedef struct {
        logic          rd;
        logic [6:0]    chip;
        logic [7:0]    ra;
        logic [DW-1:0] wd;
    } txn_t;

    typedef struct {
        int            who;
        logic          rd;
        logic [6:0]    chip;
        logic [7:0]    ra;
        logic [DW-1:0] wd;
        logic [DW-1:0] data;
        logic [3:0]    st;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    i2c_master_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    i2c_master_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .START_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int passed = 0;
    int total  = 0;
    bit tmo_mode = 1'b0;

    txn_t rq [N][$];
    logic [N-1:0] outst = '0;
    exp_t exp_q [$];

    task automatic check(input string nm, input bit ok,
                         input string act, input string req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %s, expected %s", nm, act, req);
    endtask

    task automatic push(input int who, input logic rd, input logic [6:0] chip,
                        input logic [7:0] ra, input logic [DW-1:0] wd);
        txn_t t;
        t.rd = rd; t.chip = chip; t.ra = ra; t.wd = wd;
        rq[who].push_back(t);
    endtask

    function automatic bit rq_empty();
        for (int i = 0; i < N; i++)
            if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string nm);
        bit done = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge clk);
            done = !bus.busy && outst == '0 && exp_q.size() == 0 && rq_empty();
        end
        check(nm, done, $sformatf("busy=%b outst=%b exp=%0d", bus.busy, outst,
              exp_q.size()), "idle within 4000 cycles");
    endtask

    task automatic check_zero(input string nm);
        bit ok;
        ok = bus.req_ack == '0 && bus.rsp_valid == '0 && !bus.m_write_en &&
             !bus.m_read_en && bus.m_chip_addr == '0 && bus.m_reg_addr == '0 &&
             bus.m_data_in == '0 && bus.rsp_data == '0 &&
             bus.rsp_status == '0 && !bus.busy;
        check(nm, ok, $sformatf(
            "ack=%b rsp=%b we=%b re=%b chip=%h reg=%h din=%h d=%h st=%h busy=%b",
            bus.req_ack, bus.rsp_valid, bus.m_write_en, bus.m_read_en,
            bus.m_chip_addr, bus.m_reg_addr, bus.m_data_in, bus.rsp_data,
            bus.rsp_status, bus.busy), "all zero");
    endtask

    // Requester driver: presents queued requests, scrambles fields after ack.
    always @(negedge clk) begin
        txn_t t;
        if (!reset) begin
            bus.req_valid     = '0;
            bus.req_read      = '0;
            bus.req_chip_addr = '0;
            bus.req_reg_addr  = '0;
            bus.req_data      = '0;
            outst             = '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (bus.req_ack[i]) begin
                    bus.req_valid[i] = 1'b0;
                    bus.req_read[i]  = ~bus.req_read[i];
                    bus.req_chip_addr[7*i +: 7] = 7'($urandom);
                    bus.req_reg_addr[8*i +: 8]  = 8'($urandom);
                    bus.req_data[DW*i +: DW]    = DW'($urandom);
                end
                if (bus.rsp_valid[i]) outst[i] = 1'b0;
                if (!outst[i] && rq[i].size() > 0) begin
                    t = rq[i].pop_front();
                    bus.req_valid[i] = 1'b1;
                    bus.req_read[i]  = t.rd;
                    bus.req_chip_addr[7*i +: 7] = t.chip;
                    bus.req_reg_addr[8*i +: 8]  = t.ra;
                    bus.req_data[DW*i +: DW]    = t.wd;
                    outst[i] = 1'b1;
                end
            end
        end
    end

    // Behavioural i2c_master with a single register-file slave at SLV.
    logic [DW-1:0] env_mem [256] = '{default: '0};
    int mm_ph = 0;
    int mm_cnt = 0;
    logic mm_rd = 1'b0;
    logic [6:0] mm_chip = '0;
    logic [7:0] mm_ra = '0;
    logic [DW-1:0] mm_wd = '0;

    always @(negedge clk) begin
        if (!reset) begin
            mm_ph = 0;
            bus.m_busy = 1'b0;
            bus.m_done = 1'b0;
            bus.m_status = '0;
            bus.m_data_out = '0;
        end else begin
            bus.m_done = 1'b0;
            case (mm_ph)
                0: if ((bus.m_write_en || bus.m_read_en) && !tmo_mode) begin
                    mm_rd = bus.m_read_en;
                    mm_chip = bus.m_chip_addr;
                    mm_ra = bus.m_reg_addr;
                    mm_wd = bus.m_data_in;
                    mm_cnt = int'($urandom_range(0, 3));
                    mm_ph = 1;
                end
                1: if (mm_cnt == 0) begin
                    bus.m_busy = 1'b1;
                    mm_cnt = int'($urandom_range(1, 6));
                    mm_ph = 2;
                end else mm_cnt--;
                2: if (mm_cnt == 0) begin
                    bus.m_busy = 1'b0;
                    bus.m_done = 1'b1;
                    mm_ph = 0;
                    if (mm_chip != SLV) begin
                        bus.m_status = NACK;
                        bus.m_data_out = '0;
                    end else if (mm_rd) begin
                        bus.m_status = 4'h0;
                        bus.m_data_out = env_mem[mm_ra];
                    end else begin
                        env_mem[mm_ra] = mm_wd;
                        bus.m_status = 4'h0;
                        bus.m_data_out = '0;
                    end
                end else mm_cnt--;
                default: mm_ph = 0;
            endcase
        end
    end

    // Reference model and monitor.
    logic [DW-1:0] ref_mem [256] = '{default: '0};
    int mrr = 0;
    int cyc = 0;
    int cmd_cyc = 0;
    bit cmd_pend = 1'b0;
    exp_t cur;
    logic [DW-1:0] last_d = '0;
    logic [3:0] last_s = '0;

    always @(posedge clk) begin
        exp_t e;
        int g;
        bit ok;
        #1;
        cyc++;
        if (!reset) begin
            exp_q.delete();
            mrr = 0;
            cmd_pend = 1'b0;
            last_d = '0;
            last_s = '0;
        end else begin
            if (cmd_pend) begin
                cmd_pend = 1'b0;
                cmd_cyc = cyc;
                ok = bus.m_write_en == !cur.rd && bus.m_read_en == cur.rd &&
                     bus.m_chip_addr == cur.chip && bus.m_reg_addr == cur.ra &&
                     bus.m_data_in == cur.wd;
                check("cmd", ok, $sformatf("we=%b re=%b %h/%h/%h",
                      bus.m_write_en, bus.m_read_en, bus.m_chip_addr,
                      bus.m_reg_addr, bus.m_data_in),
                      $sformatf("rd=%b %h/%h/%h", cur.rd, cur.chip,
                      cur.ra, cur.wd));
            end
            if (bus.req_ack != '0) begin
                g = -1;
                for (int k = 0; k < N; k++)
                    if (g < 0 && bus.req_valid[(mrr + k) % N])
                        g = (mrr + k) % N;
                check("grant", g >= 0 && bus.req_ack == (N'(1) << g),
                      $sformatf("ack=%b", bus.req_ack),
                      $sformatf("requester %0d", g));
                check("rsp_hold", bus.rsp_data == last_d &&
                      bus.rsp_status == last_s,
                      $sformatf("%h/%h", bus.rsp_data, bus.rsp_status),
                      $sformatf("%h/%h", last_d, last_s));
                if (g >= 0) begin
                    e.who = g;
                    e.rd = bus.req_read[g];
                    e.chip = bus.req_chip_addr[7*g +: 7];
                    e.ra = bus.req_reg_addr[8*g +: 8];
                    e.wd = bus.req_data[DW*g +: DW];
                    if (tmo_mode) begin
                        e.data = '0; e.st = 4'hF;
                    end else if (e.chip != SLV) begin
                        e.data = '0; e.st = NACK;
                    end else if (e.rd) begin
                        e.data = ref_mem[e.ra]; e.st = 4'h0;
                    end else begin
                        ref_mem[e.ra] = e.wd;
                        e.data = '0; e.st = 4'h0;
                    end
                    exp_q.push_back(e);
                    cur = e;
                    cmd_pend = 1'b1;
                    mrr = (g + 1) % N;
                end
            end
            if (bus.rsp_valid != '0) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1'b0,
                          $sformatf("rsp_valid=%b", bus.rsp_valid), "none");
                end else begin
                    e = exp_q.pop_front();
                    ok = bus.rsp_valid == (N'(1) << e.who) &&
                         bus.rsp_data == e.data && bus.rsp_status == e.st &&
                         bus.m_chip_addr == e.chip && bus.m_reg_addr == e.ra &&
                         bus.m_data_in == e.wd;
                    if (e.st == 4'hF) ok = ok && (cyc - cmd_cyc == TMO);
                    check("rsp", ok, $sformatf(
                          "v=%b d=%h st=%h m=%h/%h/%h dt=%0d", bus.rsp_valid,
                          bus.rsp_data, bus.rsp_status, bus.m_chip_addr,
                          bus.m_reg_addr, bus.m_data_in, cyc - cmd_cyc),
                          $sformatf("req %0d d=%h st=%h m=%h/%h/%h", e.who,
                          e.data, e.st, e.chip, e.ra, e.wd));
                    last_d = e.data;
                    last_s = e.st;
                end
            end
        end
    end

    initial begin
        bit seen;
        repeat (4) @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        reset = 1'b1;

        push(0, 1'b0, SLV, 8'h0A, 16'hB2B2);
        wait_idle("single_write");
        push(1, 1'b1, SLV, 8'h0A, 16'h0000);
        wait_idle("read_back");

        push(2, 1'b1, SLV, 8'h0A, 16'h0000);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk);
            #1;
            seen = bus.m_busy;
        end
        check("reach_wait_done", seen, $sformatf("m_busy=%b", bus.m_busy), "1");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_zero("reset_mid_transfer");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        push(0, 1'b1, SLV, 8'h0A, 16'h0000);
        push(1, 1'b0, SLV, 8'h03, 16'h1111);
        push(2, 1'b1, SLV, 8'h03, 16'h0000);
        push(3, 1'b0, SLV, 8'h04, 16'h4444);
        wait_idle("contention4");
        push(2, 1'b1, SLV, 8'h04, 16'h0000);
        push(0, 1'b1, SLV, 8'h03, 16'h0000);
        wait_idle("contention2");

        push(3, 1'b0, 7'h10, 8'h01, 16'hDEAD);
        push(3, 1'b1, SLV, 8'h0A, 16'h0000);
        wait_idle("wrong_addr");

        tmo_mode = 1'b1;
        push(2, 1'b0, SLV, 8'h05, 16'h1234);
        wait_idle("timeout");
        tmo_mode = 1'b0;
        push(1, 1'b1, SLV, 8'h05, 16'h0000);
        wait_idle("after_timeout");

        for (int t = 0; t < 80; t++) begin
            push(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) == 0) ? 7'h10 : SLV,
                 8'($urandom_range(0, 7)), DW'($urandom));
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        wait_idle("random");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/i2c_master_arbiter.md
I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 16, transfer data width (matches i2c_master DATA_BYTES*8).
REQ-003 Parameter START_TIMEOUT, default 64, clk cycles allowed for m_busy to rise after a command pulse.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 req_valid  input  NUM_REQ  per-requester request; held high until acknowledged.
REQ-007 req_read  input  NUM_REQ  per-requester direction; 1 = read, 0 = write.
REQ-008 req_chip_addr  input  7*NUM_REQ  packed 7-bit chip addresses, requester i at bits [7i+6:7i].
REQ-009 req_reg_addr  input  8*NUM_REQ  packed register addresses.
REQ-010 req_data  input  DATA_WIDTH*NUM_REQ  packed write data.
REQ-011 req_ack  output  NUM_REQ  one-hot, one-cycle pulse: request captured.
REQ-012 rsp_valid  output  NUM_REQ  one-hot, one-cycle pulse: transfer finished for that requester.
REQ-013 rsp_data  output  DATA_WIDTH  read data, valid with rsp_valid.
REQ-014 rsp_status  output  4  completion status, valid with rsp_valid.
REQ-015 m_chip_addr / m_reg_addr / m_data_in  output  7 / 8 / DATA_WIDTH  to i2c_master.
REQ-016 m_write_en / m_read_en  output  1 / 1  command pulses to i2c_master.
REQ-017 m_busy / m_done  input  1 / 1  from i2c_master.
REQ-018 m_status / m_data_out  input  4 / DATA_WIDTH  from i2c_master.
REQ-019 busy  output  1  high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP.
REQ-021 IDLE: if any req_valid, grant the first requester at or after rr_ptr (wrapping NUM_REQ-1 -> 0), latch its addr/data/direction into m_* registers, pulse req_ack for that requester, go to ISSUE.
REQ-022 ISSUE: exactly one cycle of m_write_en (write) or m_read_en (read), never both; go to WAIT_START.
REQ-023 WAIT_START: when m_busy=1 go to WAIT_DONE; if START_TIMEOUT cycles elapse with m_busy=0, go to RESP with status 4'hF and data 0.
REQ-024 WAIT_DONE: on m_done=1 or m_busy=0, capture m_status and m_data_out, go to RESP.
REQ-025 RESP: one-cycle rsp_valid for the granted requester with captured rsp_data/rsp_status; set rr_ptr = granted+1 mod NUM_REQ; return to IDLE.
REQ-026 m_chip_addr/m_reg_addr/m_data_in SHALL stay stable from ISSUE through RESP.
REQ-027 Latency: req_valid sampled in IDLE -> req_ack same cycle -> command pulse next cycle.
REQ-028 Requests arriving while busy SHALL wait; none dropped, none served twice.
REQ-029 Simultaneous requests: round-robin order from rr_ptr; no requester waits more than NUM_REQ-1 grants.
REQ-030 req_valid deasserted before ack SHALL not be granted; changes after ack SHALL not affect the transfer.
REQ-031 rsp_data/rsp_status SHALL hold their last values between responses.
REQ-032 Min IDLE gap: one cycle between RESP and next ISSUE.

Reset
REQ-033 reset=0 at a clock edge SHALL force IDLE, rr_ptr=0, timeout counter=0, req_ack=0, rsp_valid=0, m_write_en=0, m_read_en=0, m_* address/data=0, rsp_data=0, rsp_status=0, busy=0.
REQ-034 Reset mid-transfer SHALL abort with no rsp_valid; the i2c_master shares the same reset.

Verification
REQ-035 Single write: req 0 write chip 7'h0F reg 8'h0A data 16'hB2B2 -> one m_write_en pulse, slave reg 0x0A = 16'hB2B2, rsp_valid[0] once.
REQ-036 Read-back: req 1 read chip 7'h0F reg 8'h0A -> m_read_en pulse, rsp_data = 16'hB2B2, rsp_valid[1].
REQ-037 Contention: all 4 valid same cycle after reset -> grants 0,1,2,3 in order; then req 2 and 0 together -> grant 0 (rr_ptr=0 after wrap).
REQ-038 Wrong address: chip 7'h10 (no slave) -> rsp_status = master NACK status, bus released, next request served normally.
REQ-039 Timeout: m_busy tied 0 -> rsp_status 4'hF exactly START_TIMEOUT cycles after pulse.
REQ-040 Reset during WAIT_DONE -> all outputs zero next cycle, no rsp_valid, fresh request then completes correctly.
